// File: rtl/async_fifo_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_ctrl_if
// Bus between the write-domain pointer controller of the UART async FIFO and
// its neighbours (write requester, read domain, dual-port RAM).
//   wr_en_i    write request, one entry per cycle
//   rd_gray_i  read-domain Gray pointer, not yet synchronised
//   wen_o      RAM write strobe
//   waddr_o    RAM write address
//   wr_gray_o  registered Gray write pointer for the read domain
//   full_o     FIFO full
//   afull_o    fill level at or above the almost-full threshold
//   wcount_o   fill level seen from the write domain
// master: the environment driving requests; slave: the controller.
// ---------------------------------------------------------------------------
interface async_fifo_wr_ctrl_if #(
   parameter int AW = 5
);
   logic          wr_en_i;
   logic [AW:0]   rd_gray_i;
   logic          wen_o;
   logic [AW-1:0] waddr_o;
   logic [AW:0]   wr_gray_o;
   logic          full_o;
   logic          afull_o;
   logic [AW:0]   wcount_o;

   modport master (
      output wr_en_i, rd_gray_i,
      input  wen_o, waddr_o, wr_gray_o, full_o, afull_o, wcount_o
   );

   modport slave (
      input  wr_en_i, rd_gray_i,
      output wen_o, waddr_o, wr_gray_o, full_o, afull_o, wcount_o
   );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_ctrl
// Write-domain pointer controller of the UART async FIFO. Advances the binary
// write pointer on accepted writes, drives the RAM strobe/address, publishes
// a registered Gray write pointer, and brings the read pointer across with a
// 2-flop synchroniser to derive full, almost-full and fill level.
// Ports:
//   clk    write-domain clock
//   rst_n  asynchronous active-low reset
//   bus    async_fifo_wr_ctrl_if.slave (request, read pointer in; RAM
//          strobe/address, Gray pointer, flags and level out)
// ---------------------------------------------------------------------------
module async_fifo_wr_ctrl #(
   parameter int DEPTH        = 32,
   parameter int AFULL_THRESH = DEPTH - 4
) (
   input logic                 clk,
   input logic                 rst_n,
   async_fifo_wr_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b     = '0;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [AW:0] wbin_r;
   logic [AW:0] wgray_r;
   logic [AW:0] rq1_r;
   logic [AW:0] rq2_r;
   logic [AW:0] wcount_r;
   logic        full_r;
   logic        afull_r;

   logic        inc_s;
   logic [AW:0] wbin_next_s;
   logic [AW:0] wgray_next_s;
   logic [AW:0] rbin_s;
   logic [AW:0] level_next_s;
   logic [AW:0] full_gray_s;

   // Next-pointer, read-pointer decode and next fill level
   always_comb begin
      inc_s        = 1'b0;
      wbin_next_s  = wbin_r;
      wgray_next_s = wgray_r;
      rbin_s       = '0;
      level_next_s = '0;
      full_gray_s  = '0;

      inc_s        = bus.wr_en_i & ~full_r;
      wbin_next_s  = wbin_r + {{AW{1'b0}}, inc_s};
      wgray_next_s = bin2gray(wbin_next_s);
      rbin_s       = gray2bin(rq2_r);
      // Modulo-2^(AW+1) difference is the true level since it never exceeds DEPTH.
      level_next_s = wbin_next_s - rbin_s;
      // Write pointer is exactly DEPTH ahead when its Gray code equals the
      // read Gray code with the two top bits inverted.
      full_gray_s  = {~rq2_r[AW:AW-1], rq2_r[AW-2:0]};
   end

   // Binary and Gray write pointers load together every edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_r  <= '0;
         wgray_r <= '0;
      end else begin
         wbin_r  <= wbin_next_s;
         wgray_r <= wgray_next_s;
      end
   end

   // Two-flop synchroniser for the read-domain Gray pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq1_r <= '0;
         rq2_r <= '0;
      end else begin
         rq1_r <= bus.rd_gray_i;
         rq2_r <= rq1_r;
      end
   end

   // Registered full, almost-full and fill level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_r   <= 1'b0;
         afull_r  <= 1'b0;
         wcount_r <= '0;
      end else begin
         full_r   <= (wgray_next_s == full_gray_s);
         afull_r  <= (level_next_s >= AFULL_LVL);
         wcount_r <= level_next_s;
      end
   end

   assign bus.wen_o     = inc_s;
   assign bus.waddr_o   = wbin_r[AW-1:0];
   assign bus.wr_gray_o = wgray_r;
   assign bus.full_o    = full_r;
   assign bus.afull_o   = afull_r;
   assign bus.wcount_o  = wcount_r;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
module tb_async_fifo_wr_ctrl;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int THR   = 28;

   logic clk;
   logic rst_n;

   async_fifo_wr_ctrl_if #(.AW(AW)) bus ();

   async_fifo_wr_ctrl #(.DEPTH(DEPTH), .AFULL_THRESH(THR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit wen;
      int waddr;
      int wgray;
      bit full;
      bit afull;
      int wcount;
   } exp_t;

   exp_t sb[$];
   int   pushes = 0;
   bit   done   = 1'b0;

   // Reference model: total entries written, total entries read, and the
   // read totals that the write side can see (two edges late).
   int   m_w;
   int   m_count;
   bit   m_full;
   bit   m_afull;
   int   vis_q[$];
   int   rtot;

   function automatic int gray(input int v);
      return v ^ (v >> 1);
   endfunction

   task automatic model_reset();
      m_w     = 0;
      m_count = 0;
      m_full  = 1'b0;
      m_afull = 1'b0;
      vis_q   = '{0, 0};
      rtot    = 0;
   endtask

   // One clock cycle: apply inputs, record expectations, advance the model.
   task automatic cycle(input bit rst, input bit wr);
      exp_t e;
      int   vis;
      if (!rst) begin
         rst_n = 1'b0;
         model_reset();
      end else begin
         rst_n = 1'b1;
      end
      bus.wr_en_i   = wr;
      bus.rd_gray_i = (AW+1)'(gray(rtot % (2*DEPTH)));
      e.wen    = wr && !m_full;
      e.waddr  = m_w % DEPTH;
      e.wgray  = gray(m_w % (2*DEPTH));
      e.full   = m_full;
      e.afull  = m_afull;
      e.wcount = m_count;
      sb.push_back(e);
      pushes++;
      @(posedge clk);
      #2;
      if (rst) begin
         if (wr && !m_full) m_w++;
         vis = vis_q.pop_front();
         vis_q.push_back(rtot);
         m_count = m_w - vis;
         m_full  = (m_count == DEPTH);
         m_afull = (m_count >= THR);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
   endtask

   // Stimulus
   initial begin
      rst_n         = 1'b0;
      bus.wr_en_i   = 1'b0;
      bus.rd_gray_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      // Reset state, then reset asserted mid-burst
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b0);
      // Fill to full with no reads, plus blocked requests
      for (int i = 0; i < 35; i++) cycle(1'b1, 1'b1);
      // Release one entry
      rtot = 1;
      idle(4);
      // Write on the edge where the read release lands
      rtot = 2;
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      idle(3);
      // Drain to 27, then cross the almost-full boundary both ways
      while (rtot < 6) begin
         rtot++;
         cycle(1'b1, 1'b0);
      end
      idle(4);
      cycle(1'b1, 1'b1);
      idle(1);
      rtot++;
      idle(4);
      // Wrap-around with reads trailing the writes
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 70; i++) begin
         if (m_w - 2 > rtot) rtot++;
         cycle(1'b1, 1'b1);
      end
      idle(4);
      // Random traffic with drifting read rate and occasional resets
      for (int i = 0; i < 800; i++) begin
         int rd_pct;
         rd_pct = ((i / 100) % 2 == 0) ? 30 : 85;
         if ($urandom_range(0, 99) < rd_pct && rtot < m_w) rtot++;
         cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) < 70));
      end
      idle(4);
      done = 1'b1;
   end

   int checks = 0;
   int errors = 0;
   int pops   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Monitor: pops one expectation per cycle mid-cycle and compares
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) break;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            pops++;
            chk("wen",    int'(bus.wen_o),     int'(e.wen));
            chk("waddr",  int'(bus.waddr_o),   e.waddr);
            chk("wgray",  int'(bus.wr_gray_o), e.wgray);
            chk("full",   int'(bus.full_o),    int'(e.full));
            chk("afull",  int'(bus.afull_o),   int'(e.afull));
            chk("wcount", int'(bus.wcount_o),  e.wcount);
         end
      end
      chk("sb_drained", sb.size(), 0);
      chk("sb_count", pops, pushes);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit
   initial begin
      #500000;
      $display("FAIL timeout: run did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
